// File: rtl/wash_panel.sv
// Washing-machine front panel: key edge detection, power/run/done sequencing,
// program and load selection, end-of-cycle buzzer and idle auto power-off.
module wash_panel #(
   parameter int ALARM_T = 5,
   parameter int IDLE_T  = 30
) (
   input  logic       clk_s,
   input  logic       reset,
   input  logic       btn_power,
   input  logic       btn_start,
   input  logic       btn_mode,
   input  logic       btn_weight,
   input  logic       finish,
   input  logic       flag_run,
   output logic       power_led,
   output logic       pause_led,
   output logic [5:0] mode,
   output logic [2:0] weight,
   output logic       flag_finish,
   output logic       buzzer
);

   typedef enum logic [1:0] {
      ST_OFF  = 2'd0,
      ST_IDLE = 2'd1,
      ST_RUN  = 2'd2,
      ST_DONE = 2'd3
   } state_t;

   localparam logic [7:0] ALARM_LD = 8'(ALARM_T);
   localparam logic [7:0] IDLE_LIM = 8'(IDLE_T - 1);

   state_t      state_r;
   state_t      state_next_s;
   logic        power_led_r;
   logic        pause_led_r;
   logic        flag_finish_r;
   logic        buzzer_r;
   logic [5:0]  mode_r;
   logic [2:0]  weight_r;
   logic [7:0]  alarm_cnt_r;
   logic [7:0]  idle_cnt_r;
   logic        prev_power_r;
   logic        prev_start_r;
   logic        prev_mode_r;
   logic        prev_weight_r;
   logic        prev_finish_r;
   // Suppresses key events in the first cycle after reset so a held key is not seen as a press.
   logic        armed_r;

   logic        press_power_s;
   logic        press_start_s;
   logic        press_mode_s;
   logic        press_weight_s;
   logic        press_any_s;
   logic        fin_edge_s;
   logic        powered_s;
   logic        idle_cond_s;
   logic        timeout_s;
   logic        power_off_s;
   logic        fin_act_s;
   logic        edit_ok_s;

   // Key/finish edge detection and the qualifying conditions shared by the state and datapath.
   always_comb begin
      press_power_s  = armed_r & btn_power  & ~prev_power_r;
      press_start_s  = armed_r & btn_start  & ~prev_start_r;
      press_mode_s   = armed_r & btn_mode   & ~prev_mode_r;
      press_weight_s = armed_r & btn_weight & ~prev_weight_r;
      press_any_s    = press_power_s | press_start_s | press_mode_s | press_weight_s;
      fin_edge_s     = finish & ~prev_finish_r;
      powered_s      = (state_r != ST_OFF);
      idle_cond_s    = ((state_r == ST_IDLE) || (state_r == ST_DONE)) & ~flag_run;
      timeout_s      = idle_cond_s & ~press_any_s & (idle_cnt_r >= IDLE_LIM);
      power_off_s    = (press_power_s & powered_s) | timeout_s;
      fin_act_s      = fin_edge_s & powered_s & ~power_off_s;
      edit_ok_s      = idle_cond_s & ~press_power_s & ~press_start_s;
   end

   // Next-state selection; power-off outranks finish, which outranks a start press.
   always_comb begin
      state_next_s = state_r;
      case (state_r)
         ST_OFF: begin
            if (press_power_s) state_next_s = ST_IDLE;
            else               state_next_s = ST_OFF;
         end
         ST_IDLE, ST_DONE: begin
            if (power_off_s)        state_next_s = ST_OFF;
            else if (fin_edge_s)    state_next_s = ST_DONE;
            else if (press_start_s) state_next_s = ST_RUN;
            else                    state_next_s = state_r;
         end
         ST_RUN: begin
            if (power_off_s)        state_next_s = ST_OFF;
            else if (fin_edge_s)    state_next_s = ST_DONE;
            else if (press_start_s) state_next_s = ST_IDLE;
            else                    state_next_s = ST_RUN;
         end
         default: state_next_s = ST_OFF;
      endcase
   end

   // State register with the status LEDs registered from the next state.
   always_ff @(posedge clk_s) begin
      if (!reset) begin
         state_r       <= ST_OFF;
         power_led_r   <= 1'b0;
         pause_led_r   <= 1'b0;
         flag_finish_r <= 1'b0;
      end else begin
         state_r       <= state_next_s;
         power_led_r   <= (state_next_s != ST_OFF);
         pause_led_r   <= (state_next_s == ST_RUN);
         flag_finish_r <= (state_next_s == ST_DONE);
      end
   end

   // Previous levels, buzzer/alarm countdown, idle counter and program/weight selection.
   always_ff @(posedge clk_s) begin
      if (!reset) begin
         prev_power_r  <= 1'b0;
         prev_start_r  <= 1'b0;
         prev_mode_r   <= 1'b0;
         prev_weight_r <= 1'b0;
         prev_finish_r <= 1'b0;
         armed_r       <= 1'b0;
         buzzer_r      <= 1'b0;
         alarm_cnt_r   <= 8'd0;
         idle_cnt_r    <= 8'd0;
         mode_r        <= 6'b100000;
         weight_r      <= 3'd3;
      end else begin
         prev_power_r  <= btn_power;
         prev_start_r  <= btn_start;
         prev_mode_r   <= btn_mode;
         prev_weight_r <= btn_weight;
         prev_finish_r <= finish;
         armed_r       <= 1'b1;

         if (power_off_s) begin
            buzzer_r    <= 1'b0;
            alarm_cnt_r <= 8'd0;
         end else if (fin_act_s) begin
            buzzer_r    <= (ALARM_LD != 8'd0);
            alarm_cnt_r <= ALARM_LD;
         end else if (press_any_s) begin
            buzzer_r    <= 1'b0;
            alarm_cnt_r <= 8'd0;
         end else if (buzzer_r) begin
            buzzer_r    <= (alarm_cnt_r != 8'd1);
            alarm_cnt_r <= alarm_cnt_r - 8'd1;
         end else begin
            buzzer_r    <= 1'b0;
            alarm_cnt_r <= alarm_cnt_r;
         end

         if (power_off_s || press_any_s || !idle_cond_s) begin
            idle_cnt_r <= 8'd0;
         end else if (idle_cnt_r != 8'hFF) begin
            idle_cnt_r <= idle_cnt_r + 8'd1;
         end else begin
            idle_cnt_r <= idle_cnt_r;
         end

         if (edit_ok_s && press_mode_s) begin
            mode_r <= {mode_r[0], mode_r[5:1]};
         end else begin
            mode_r <= mode_r;
         end

         if (edit_ok_s && !press_mode_s && press_weight_s) begin
            weight_r <= (weight_r == 3'd7) ? 3'd1 : (weight_r + 3'd1);
         end else begin
            weight_r <= weight_r;
         end
      end
   end

   assign power_led   = power_led_r;
   assign pause_led   = pause_led_r;
   assign flag_finish = flag_finish_r;
   assign buzzer      = buzzer_r;
   assign mode        = mode_r;
   assign weight      = weight_r;

endmodule

// File: doc/wash_panel.md
WASH_PANEL -- requirements
Module: wash_panel

Interface
REQ-001 Parameter ALARM_T, default 5: buzzer duration in clk_s ticks after a wash finishes.
REQ-002 Parameter IDLE_T, default 30: idle ticks before auto power-off.
REQ-003 clk_s  in  1  panel/wash clock; all logic rises on posedge clk_s.
REQ-004 reset  in  1  reset, synchronous, active-low; clock clk_s.
REQ-005 btn_power  in  1  power key level, debounced, synchronous to clk_s.
REQ-006 btn_start  in  1  start/pause key level.
REQ-007 btn_mode  in  1  mode-select key level.
REQ-008 btn_weight  in  1  weight-select key level.
REQ-009 finish  in  1  wash-controller done flag.
REQ-010 flag_run  in  1  wash-controller busy flag.
REQ-011 power_led  out  1  1 = machine powered.
REQ-012 pause_led  out  1  1 = running, 0 = paused/idle.
REQ-013 mode  out  6  one-hot program select:
- 100000 = full;
- 010000 = wash only;
- 001000 = wash+rinse;
- 000100 = rinse only;
- 000010 = rinse+spin;
- 000001 = spin only.
REQ-014 weight  out  3  load weight, legal range 1..7.
REQ-015 flag_finish  out  1  1 = cycle complete, inhibits the wash controller.
REQ-016 buzzer  out  1  done alarm.

Function
REQ-017 Each key SHALL register its previous level. A press SHALL be level=1 while the previous level=0, one event per press; holding a key SHALL produce no repeats.
REQ-018 When presses coincide in one cycle, exactly one SHALL be acted on, with priority power > start > mode > weight.
REQ-019 A power press SHALL toggle power_led.
REQ-020 Power-off SHALL happen by key (REQ-019) or by auto-off (REQ-026). On power-off, in the same cycle: pause_led=0, flag_finish=0, buzzer=0, alarm counter=0, idle counter=0. Mode and weight SHALL retain their values.
REQ-021 While power_led=0, all keys except power SHALL be ignored, and the finish edge detect SHALL still track finish.
REQ-022 Start press with power_led=1 SHALL toggle pause_led. On the 0->1 transition, flag_finish SHALL be cleared to 0 in the same cycle.
REQ-023 Mode press SHALL rotate mode one position right, with 000001 wrapping to 100000. It SHALL act only if power_led=1, pause_led=0 and flag_run=0; otherwise it SHALL be ignored.
REQ-024 Weight press SHALL increment weight, with 7 wrapping to 1. It is gated exactly as REQ-023.
REQ-025 Finish rising edge (finish=1, previous=0) while power_led=1 SHALL, next cycle:
- set flag_finish=1;
- set pause_led=0;
- set buzzer=1;
- load the alarm counter with ALARM_T.
A finish edge and a start press in the same cycle: finish SHALL win and the start press SHALL be dropped.
REQ-026 Alarm counter (8-bit):
- SHALL decrement once per tick while buzzer=1;
- buzzer SHALL drop in the cycle the counter reaches 0, so buzzer is high for exactly ALARM_T cycles;
- any key press SHALL clear buzzer and the counter immediately, and the press SHALL still be processed.
REQ-027 Idle counter (8-bit, saturating):
- SHALL increment each tick while power_led=1, pause_led=0 and flag_run=0;
- SHALL clear on any press or when that condition is false;
- reaching IDLE_T SHALL power off per REQ-020.
REQ-028 The panel is a state machine with states OFF, IDLE (on, paused), RUN (on, pause_led=1) and DONE (on, flag_finish=1, paused). Transitions:
- OFF->IDLE: power press;
- IDLE->RUN and DONE->RUN: start press;
- RUN->IDLE: start press;
- RUN->DONE: finish edge;
- any state->OFF: power press or idle timeout.
The outputs SHALL be consistent with the state at all times.
REQ-029 The panel SHALL NOT alter mode or weight while flag_run=1, even after a pause.

Reset
REQ-030 With reset=0 at a clock edge:
- power_led=0, pause_led=0, flag_finish=0, buzzer=0;
- mode=100000, weight=3;
- alarm counter=0, idle counter=0;
- all key and finish previous-level registers = 0.
REQ-031 A reset asserted mid-run SHALL override all key and finish events in that cycle.
REQ-032 A key held through reset release SHALL NOT generate a press.

Verification
REQ-033 Reset, power press, then three mode presses -> power_led=1, mode=000100; weight press x5 -> weight 3->4->5->6->7->1.
REQ-034 Power on, start press -> pause_led=1. With flag_run=1: mode press -> mode unchanged; start press -> pause_led=0, mode still locked.
REQ-035 Running with flag_run=1, finish pulses 0->1 -> next cycle flag_finish=1, pause_led=0, buzzer=1 for exactly 5 cycles; start press afterwards -> flag_finish=0, pause_led=1.
REQ-036 btn_power, btn_start and btn_mode rise in the same cycle while IDLE -> only power acts: power_led=0, pause_led=0, mode unchanged.
REQ-037 Power on, no keys, flag_run=0 -> power_led falls after exactly 30 idle ticks; a key press at tick 29 restarts the count.
REQ-038 reset=0 while RUN with buzzer active -> all outputs at their reset values on the next edge; btn_start held high across release -> no toggle.
